// File: rtl/ysyx_22050039_core.sv
// ysyx_22050039_core: multi-cycle RV32I/RV64I subset core (addi, add, lui, auipc, jal, jalr, ebreak).
// Define YSYX_22050039_COMMIT_EN to add the commit_valid/commit_pc/commit_inst retire ports.
module ysyx_22050039_core #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic            bad_inst,
  output logic [XLEN-1:0] halt_code
`ifdef YSYX_22050039_COMMIT_EN
  ,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_inst
`endif
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [XLEN-1:0] PC_INIT = RESET_PC[XLEN-1:0];
  localparam logic [31:0]     EBREAK  = 32'h0010_0073;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  logic [1:0]      state;
  logic            out_of_reset;
  logic [31:0]     inst_reg;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] pc_plus4;

  logic            wb_en;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] next_pc;
  logic            is_ebreak;
  logic            is_bad;

  assign opcode = inst_reg[6:0];
  assign rd     = inst_reg[11:7];
  assign funct3 = inst_reg[14:12];
  assign rs1    = inst_reg[19:15];
  assign rs2    = inst_reg[24:20];
  assign funct7 = inst_reg[31:25];

  // rf[0] is never written, so it keeps its reset value and x0 reads as zero
  assign rs1_val  = rf[rs1];
  assign rs2_val  = rf[rs2];
  assign imm_i    = XLEN'($signed(inst_reg[31:20]));
  assign imm_u    = XLEN'($signed({inst_reg[31:12], 12'b0}));
  assign imm_j    = XLEN'($signed({inst_reg[31], inst_reg[19:12], inst_reg[20], inst_reg[30:21], 1'b0}));
  assign pc_plus4 = pc + XLEN'(4);

  assign imem_req_valid = (state == FETCH) && out_of_reset;
  assign imem_req_addr  = pc;

`ifdef YSYX_22050039_COMMIT_EN
  assign commit_valid = (state == EXEC);
  assign commit_pc    = pc;
  assign commit_inst  = inst_reg;
`endif

  always_comb begin
    wb_en     = 1'b0;
    wb_data   = '0;
    next_pc   = pc_plus4;
    is_ebreak = 1'b0;
    is_bad    = 1'b0;
    case (opcode)
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = rs1_val + imm_i;
        end else begin
          is_bad = 1'b1;
        end
      end
      OP_REG: begin
        if (funct3 == 3'b000 && funct7 == 7'b0) begin
          wb_en   = 1'b1;
          wb_data = rs1_val + rs2_val;
        end else begin
          is_bad = 1'b1;
        end
      end
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUI: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JLR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~XLEN'(1);
        end else begin
          is_bad = 1'b1;
        end
      end
      OP_SYS: begin
        if (inst_reg == EBREAK) is_ebreak = 1'b1;
        else                    is_bad    = 1'b1;
      end
      default: is_bad = 1'b1;
    endcase
  end

  // Aborting in WAIT/EXEC on reset is free: nothing architectural changes before the EXEC edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      out_of_reset <= 1'b0;
      pc           <= PC_INIT;
      inst_reg     <= '0;
      halted       <= 1'b0;
      bad_inst     <= 1'b0;
      halt_code    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        FETCH: begin
          if (out_of_reset && imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_reg <= imem_rsp_data;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (is_ebreak || is_bad) begin
            halted    <= 1'b1;
            bad_inst  <= is_bad;
            halt_code <= rf[10];
            state     <= HALT;
          end else begin
            if (wb_en && rd != 5'd0) rf[rd] <= wb_data;
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_core.sv
// Scoreboard bench for ysyx_22050039_core: an ISA-level reference model predicts fetch addresses
// and the halt record; a monitor pops and compares them as the core presents requests and halts.
module tb_ysyx_22050039_core;

  localparam logic [63:0] RPC  = 64'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] code;
    logic        bad;
  } halt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic [63:0] pc;
  logic        halted;
  logic        bad_inst;
  logic [63:0] halt_code;

  logic        v32;
  logic        rdy32 = 1'b1;
  logic [31:0] a32;
  logic        rv32 = 1'b0;
  logic [31:0] d32 = 32'h0;
  logic [31:0] pc32;
  logic        h32;
  logic        b32;
  logic [31:0] hc32;

  logic [31:0] mem [logic [63:0]];
  logic [31:0] prog [$];
  logic [63:0] model_fetch [$];
  logic [63:0] exp_addr [$];
  halt_t       halt_q [$];

  int compares = 0;
  int fails    = 0;
  int cyc      = 0;
  bit rand_stall = 1'b0;
  int one_rdy = -1;
  int one_rsp = -1;

  ysyx_22050039_core #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .pc(pc), .halted(halted), .bad_inst(bad_inst), .halt_code(halt_code)
  );

  ysyx_22050039_core #(.XLEN(32), .RESET_PC(64'h8000_0000)) dut32 (
    .clk(clk), .rst(rst),
    .imem_req_valid(v32), .imem_req_ready(rdy32), .imem_req_addr(a32),
    .imem_rsp_valid(rv32), .imem_rsp_data(d32),
    .pc(pc32), .halted(h32), .bad_inst(b32), .halt_code(hc32)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [31:0] memrd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
    logic signed [63:0] t;
    t = $signed(v << (64 - bits));
    return $unsigned(t >>> (64 - bits));
  endfunction

  function automatic logic [63:0] msk(input logic [63:0] v, input int xlen);
    return (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
  endfunction

  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction
  function automatic logic [31:0] f_auipc(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h17};
  endfunction
  function automatic logic [31:0] f_jal(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] f_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h67};
  endfunction

  // Instruction-set interpreter: registers as an array, pc as a number, one loop step per instruction
  task automatic model_run(input int xlen, output halt_t res, output bit ok);
    logic [63:0] x [32];
    logic [63:0] p, r1, r2, val, np;
    logic [31:0] in;
    bit stop, bad;
    for (int i = 0; i < 32; i++) x[i] = '0;
    p = msk(RPC, xlen);
    ok = 1'b0;
    res.pc = '0; res.code = '0; res.bad = 1'b0;
    model_fetch.delete();
    for (int step = 0; step < 300 && !ok; step++) begin
      model_fetch.push_back(p);
      in   = memrd(p);
      r1   = x[in[19:15]];
      r2   = x[in[24:20]];
      val  = p + 64'd4;
      np   = p + 64'd4;
      stop = 1'b0;
      bad  = 1'b0;
      case (in[6:0])
        7'h13: if (in[14:12] == 3'b000) val = r1 + sx(64'(in[31:20]), 12); else bad = 1'b1;
        7'h33: if (in[14:12] == 3'b000 && in[31:25] == 7'b0) val = r1 + r2; else bad = 1'b1;
        7'h37: val = sx(64'({in[31:12], 12'b0}), 32);
        7'h17: val = p + sx(64'({in[31:12], 12'b0}), 32);
        7'h6F: np = p + sx(64'({in[31], in[19:12], in[20], in[30:21], 1'b0}), 21);
        7'h67: if (in[14:12] == 3'b000) np = (r1 + sx(64'(in[31:20]), 12)) & ~64'd1; else bad = 1'b1;
        7'h73: if (in == EBRK) stop = 1'b1; else bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (stop || bad) begin
        res.pc   = p;
        res.code = x[10];
        res.bad  = bad;
        ok       = 1'b1;
      end else begin
        if (in[11:7] != 5'd0) x[in[11:7]] = msk(val, xlen);
        p = msk(np, xlen);
      end
    end
  endtask

  task automatic load_prog();
    mem.delete();
    foreach (prog[i]) mem[RPC + 64'(4 * i)] = prog[i];
  endtask

  function automatic int next_rdy();
    int r;
    if (one_rdy >= 0) begin r = one_rdy; one_rdy = -1; end
    else r = rand_stall ? int'($urandom_range(0, 2)) : 0;
    return r;
  endfunction

  function automatic int next_rsp();
    int r;
    if (one_rsp >= 0) begin r = one_rsp; one_rsp = -1; end
    else r = rand_stall ? int'($urandom_range(0, 3)) : 0;
    return r;
  endfunction

  // Memory responder for the 64-bit core: drives ready/response at the falling edge
  initial begin : responder
    bit pend, hs_next, rsp_next;
    int rdy_wait, rsp_wait;
    logic [63:0] pend_addr, hs_addr;
    pend = 0; hs_next = 0; rsp_next = 0; rdy_wait = -1; rsp_wait = 0;
    pend_addr = '0; hs_addr = '0;
    forever begin
      @(negedge clk);
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      if (!rst) begin
        pend = 0; hs_next = 0; rsp_next = 0; rdy_wait = -1;
      end else begin
        if (hs_next) begin pend = 1; pend_addr = hs_addr; rsp_wait = next_rsp(); hs_next = 0; end
        if (rsp_next) begin pend = 0; rsp_next = 0; rdy_wait = -1; end
        if (pend) begin
          if (rsp_wait > 0) rsp_wait--;
          else begin rsp_valid = 1'b1; rsp_data = memrd(pend_addr); rsp_next = 1; end
        end else if (req_valid) begin
          if (rdy_wait < 0) rdy_wait = next_rdy();
          if (rdy_wait > 0) rdy_wait--;
          else begin req_ready = 1'b1; hs_next = 1; hs_addr = req_addr; end
        end
      end
    end
  end

  // Zero-wait memory for the 32-bit core: always ready, answers in the following cycle
  initial begin : responder32
    bit p32;
    logic [31:0] pa32;
    p32 = 0; pa32 = '0;
    forever begin
      @(negedge clk);
      rv32 = 1'b0;
      if (!rst) p32 = 0;
      else if (p32) begin rv32 = 1'b1; d32 = memrd({32'h0, pa32}); p32 = 0; end
      else if (v32) begin p32 = 1; pa32 = a32; end
    end
  end

  initial begin : monitor
    bit prev_stall, prev_h;
    logic [63:0] stall_addr;
    halt_t h;
    prev_stall = 0; prev_h = 0; stall_addr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_stall = 0;
        prev_h     = 0;
      end else begin
        if (prev_stall) begin
          check("req_hold_valid", 64'(req_valid), 64'd1);
          check("req_hold_addr", req_addr, stall_addr);
        end
        prev_stall = req_valid && !req_ready;
        stall_addr = req_addr;
        if (req_valid && req_ready) begin
          if (exp_addr.size() == 0) begin
            compares++; fails++;
            $display("[TB] FAIL unexpected_fetch: got addr %h, expected no request", req_addr);
          end else begin
            check("fetch_addr", req_addr, exp_addr.pop_front());
          end
        end
        if (halted && !prev_h) begin
          if (halt_q.size() == 0) begin
            compares++; fails++;
            $display("[TB] FAIL unexpected_halt: got halted=1 at pc %h, expected running", pc);
          end else begin
            h = halt_q.pop_front();
            check("halt_pc", pc, h.pc);
            check("halt_code", halt_code, h.code);
            check("halt_bad", 64'(bad_inst), 64'(h.bad));
          end
        end
        prev_h = halted;
      end
    end
  end

  task automatic start_prog();
    halt_t h;
    bit ok;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_pc", pc, RPC);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_halt_code", halt_code, 64'd0);
    exp_addr.delete();
    halt_q.delete();
    model_run(64, h, ok);
    foreach (model_fetch[i]) exp_addr.push_back(model_fetch[i]);
    halt_q.push_back(h);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic finish_prog(input string tag);
    int n;
    n = 0;
    while (!halted && n < 4000) begin tick(); n++; end
    if (!halted) begin
      compares++; fails++;
      $display("[TB] FAIL %s_timeout: halted=0 after %0d cycles, expected 1", tag, n);
    end
    tick();
    tick();
    check({tag, "_fetch_left"}, 64'(exp_addr.size()), 64'd0);
    check({tag, "_halt_left"}, 64'(halt_q.size()), 64'd0);
  endtask

  task automatic check_absorbing(input string tag);
    logic [63:0] pc_h;
    int cnt;
    pc_h = pc;
    cnt  = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (req_valid || pc != pc_h || !halted) cnt++;
    end
    check({tag, "_absorbing"}, 64'(cnt), 64'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!req_valid && n < 10) begin tick(); n++; end
    if (!req_valid) begin
      compares++; fails++;
      $display("[TB] FAIL %s_no_request: got valid=0, expected 1", tag);
    end
  endtask

  task automatic gen_random();
    int n, k;
    logic [4:0] regs [5];
    logic [4:0] a, b, c;
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd10;
    n = $urandom_range(4, 10);
    prog.delete();
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 11);
      a = regs[$urandom_range(0, 4)];
      b = regs[$urandom_range(0, 4)];
      c = regs[$urandom_range(0, 4)];
      case (k)
        0, 1, 2: prog.push_back(f_addi(a, b, 12'($urandom())));
        3, 4:    prog.push_back(f_add(a, b, c));
        5:       prog.push_back(f_lui(a, 20'($urandom())));
        6:       prog.push_back(f_auipc(a, 20'($urandom())));
        7, 8:    prog.push_back(f_jal(a, 21'($urandom_range(1, 2) * 4)));
        9:       prog.push_back(f_jalr(a, b, 12'($urandom_range(0, 15))));
        default: prog.push_back(32'($urandom()));
      endcase
    end
    prog.push_back(f_addi(5'd10, regs[$urandom_range(0, 4)], 12'h0));
    prog.push_back(EBRK);
    prog.push_back(EBRK);
    load_prog();
  endtask

  initial begin : stimulus
    int c0, n;
    halt_t h;
    bit ok;

    // 1-cycle memory, first fetch timing and addi/add
    rand_stall = 1'b0;
    prog = {f_addi(5'd1, 5'd0, 12'hFFF), f_add(5'd2, 5'd1, 5'd1), f_addi(5'd10, 5'd2, 12'h0), EBRK};
    load_prog();
    start_prog();
    wait_valid("first");
    check("first_req_addr", req_addr, RPC);
    c0 = cyc;
    n  = 0;
    while (pc == RPC && n < 20) begin tick(); n++; end
    check("first_retire_cycles", 64'(cyc - c0), 64'd3);
    check("first_pc", pc, RPC + 64'd4);
    finish_prog("addadd");
    check("addadd_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFE);
    check("addadd_bad", 64'(bad_inst), 64'd0);
    check("addadd_pc", pc, 64'h8000_000C);
    check_absorbing("ebreak");

    // lui sign extension on both widths
    prog = {f_addi(5'd0, 5'd0, 12'd5), f_lui(5'd10, 20'h80000), EBRK};
    load_prog();
    start_prog();
    finish_prog("lui");
    check("lui_code64", halt_code, 64'hFFFF_FFFF_8000_0000);
    n = 0;
    while (!h32 && n < 50) begin tick(); n++; end
    check("lui_halt32", 64'(h32), 64'd1);
    check("lui_code32", 64'(hc32), 64'h0000_0000_8000_0000);
    model_run(32, h, ok);
    check("lui_code32_model", 64'(hc32), h.code);
    check("lui_pc32", 64'(pc32), h.pc);

    // x0 stays zero after a write attempt
    prog = {f_addi(5'd0, 5'd0, 12'd5), f_addi(5'd10, 5'd0, 12'd3), EBRK};
    load_prog();
    start_prog();
    finish_prog("x0");
    check("x0_code", halt_code, 64'd3);

    // jal/jalr with rd == rs1
    prog = {f_jal(5'd1, 21'd8), f_addi(5'd10, 5'd1, 12'h0), f_jalr(5'd1, 5'd1, 12'h0), EBRK};
    load_prog();
    start_prog();
    finish_prog("jump");
    check("jump_code", halt_code, 64'h8000_000C);
    check("jump_pc", pc, 64'h8000_000C);

    // unsupported encoding
    prog = {32'h0000_0000};
    load_prog();
    start_prog();
    finish_prog("badenc");
    check("badenc_bad", 64'(bad_inst), 64'd1);
    check("badenc_pc", pc, RPC);
    check_absorbing("badenc");

    // stalled first instruction, then reset during the second one's WAIT
    prog = {f_addi(5'd1, 5'd0, 12'hFFF), f_add(5'd2, 5'd1, 5'd1), f_addi(5'd10, 5'd2, 12'h0), EBRK};
    load_prog();
    one_rdy = 5;
    one_rsp = 3;
    start_prog();
    wait_valid("stall");
    c0 = cyc;
    n  = 0;
    while (pc == RPC && n < 40) begin tick(); n++; end
    check("stall_retire_cycles", 64'(cyc - c0), 64'd11);
    n = 0;
    while (!(req_valid && req_ready) && n < 10) begin tick(); n++; end
    check("stall_second_req", 64'(req_valid && req_ready), 64'd1);
    start_prog();
    finish_prog("midreset");
    check("midreset_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFE);

    // randomized programs with random handshake stalls
    rand_stall = 1'b1;
    for (int t = 0; t < 12; t++) begin
      do begin
        gen_random();
        model_run(64, h, ok);
      end while (!ok);
      start_prog();
      finish_prog("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
